oddr_tx_sequencer: RTL and testbench

//  Frame-aware 2:1 serialiser that feeds an ODDR output stage from a ready/valid word stream.

---
 rtl/oddr_tx_seq_pkg.sv | 26 ++
 rtl/oddr_tx_shifter.sv | 74 +++++++
 rtl/oddr_tx_sequencer.sv | 153 +++++++++++++++
 tb/tb_oddr_tx_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/oddr_tx_seq_pkg.sv
// Shared types and elaboration helpers for the ODDR TX sequencer and its shifter.
package oddr_tx_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SH_HOLD = 2'd0,
      SH_LOAD = 2'd1,
      SH_STEP = 2'd2,
      SH_IDLE = 2'd3
   } sh_cmd_t;

   // A single-beat word still needs a 1-bit counter so the vector stays legal.
   function automatic int beat_cnt_w(input int width);
      return (width / 2 > 1) ? $clog2(width / 2) : 1;
   endfunction

   function automatic bit params_ok(input int width, input int gap_beats);
      return (width >= 2) && (width % 2 == 0) && (gap_beats >= 0) && (gap_beats <= 255);
   endfunction

endpackage

// File: rtl/oddr_tx_shifter.sv
// Word shift register and beat counter; registers the D1/D2 pair presented to the ODDR.
module oddr_tx_shifter
   import oddr_tx_seq_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter bit   LSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b1,
   parameter int   CW         = 2
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  sh_cmd_t          cmd,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_last,
   output logic             d1,
   output logic             d2,
   output logic             last_beat,
   output logic             frame_last
);

   localparam int NB = WIDTH / 2;

   logic [WIDTH-1:0] sr_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] rest;
   logic [1:0]       pair;

   // sr_q holds only the bits not yet presented, so the next pair is always at a fixed end.
   always_comb begin
      src = (cmd == SH_LOAD) ? load_data : sr_q;
      if (LSB_FIRST) begin
         pair = {src[0], src[1]};
         rest = src >> 2;
      end else begin
         pair = {src[WIDTH-1], src[WIDTH-2]};
         rest = src << 2;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         sr_q       <= '0;
         cnt_q      <= '0;
         frame_last <= 1'b0;
         d1         <= IDLE_LEVEL;
         d2         <= IDLE_LEVEL;
      end else begin
         case (cmd)
            SH_LOAD: begin
               sr_q       <= rest;
               cnt_q      <= '0;
               frame_last <= load_last;
               d1         <= pair[1];
               d2         <= pair[0];
            end
            SH_STEP: begin
               sr_q  <= rest;
               cnt_q <= cnt_q + CW'(1);
               d1    <= pair[1];
               d2    <= pair[0];
            end
            SH_IDLE: begin
               d1 <= IDLE_LEVEL;
               d2 <= IDLE_LEVEL;
            end
            default: ;
         endcase
      end
   end

   assign last_beat = (cnt_q == CW'(NB - 1));

endmodule

// File: rtl/oddr_tx_sequencer.sv
// Frame-aware 2:1 serialiser feeding one ODDR pin from a ready/valid word stream.
// state | meaning
// IDLE  | no word in flight, idle level clocked out
// SHIFT | shifter presenting beats of the current word
// GAP   | post-frame idle beats, gap_q counts down to 1
module oddr_tx_sequencer
   import oddr_tx_seq_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter bit   LSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b1,
   parameter int   GAP_BEATS  = 2
) (
   input  logic             C,
   input  logic             RN,
   input  logic             EN,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic             IN_VALID,
   input  logic             IN_LAST,
   output logic             IN_READY,
   output logic             D1,
   output logic             D2,
   output logic             OCE,
   output logic             BUSY,
   output logic             UNDERRUN
);

   localparam int CW = beat_cnt_w(WIDTH);

   if (!params_ok(WIDTH, GAP_BEATS)) begin : g_param_check
      $error("oddr_tx_sequencer: WIDTH must be even and >= 2, GAP_BEATS within 0..255");
   end

   state_t           state_q, state_d;
   logic             hold_valid_q, hold_valid_d;
   logic             hold_last_q, hold_last_d;
   logic [WIDTH-1:0] hold_data_q, hold_data_d;
   logic [7:0]       gap_q, gap_d;
   logic             ready_q, oce_q, underrun_q, underrun_d;
   logic             accept, fetch, direct;
   sh_cmd_t          sh_cmd;
   logic [WIDTH-1:0] sh_data;
   logic             sh_last;
   logic             last_beat, frame_last;

   assign accept = IN_VALID & ready_q;

   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      gap_d        = gap_q;
      underrun_d   = 1'b0;
      fetch        = 1'b0;
      direct       = 1'b0;
      sh_cmd       = SH_HOLD;
      sh_data      = hold_data_q;
      sh_last      = hold_last_q;

      if (EN) begin
         case (state_q)
            ST_IDLE: fetch = 1'b1;
            ST_SHIFT: begin
               if (!last_beat) begin
                  sh_cmd = SH_STEP;
               end else if (frame_last && (GAP_BEATS != 0)) begin
                  state_d = ST_GAP;
                  gap_d   = 8'(GAP_BEATS);
                  sh_cmd  = SH_IDLE;
               end else begin
                  fetch = 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_q == 8'd1) fetch = 1'b1;
               else               gap_d = gap_q - 8'd1;
            end
            default: state_d = ST_IDLE;
         endcase

         // HOLD has priority over a fresh word so ordering is preserved.
         if (fetch) begin
            if (hold_valid_q) begin
               sh_cmd       = SH_LOAD;
               hold_valid_d = 1'b0;
               state_d      = ST_SHIFT;
            end else if (accept) begin
               sh_cmd  = SH_LOAD;
               sh_data = IN_DATA;
               sh_last = IN_LAST;
               direct  = 1'b1;
               state_d = ST_SHIFT;
            end else begin
               sh_cmd     = SH_IDLE;
               state_d    = ST_IDLE;
               underrun_d = (state_q == ST_SHIFT) && !frame_last;
            end
         end
      end

      if (accept && !direct) begin
         hold_valid_d = 1'b1;
         hold_data_d  = IN_DATA;
         hold_last_d  = IN_LAST;
      end
   end

   always_ff @(posedge C) begin
      if (!RN) begin
         state_q      <= ST_IDLE;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_last_q  <= 1'b0;
         gap_q        <= '0;
         ready_q      <= 1'b0;
         oce_q        <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_last_q  <= hold_last_d;
         gap_q        <= gap_d;
         ready_q      <= !hold_valid_d;
         oce_q        <= EN;
         underrun_q   <= underrun_d;
      end
   end

   oddr_tx_shifter #(
      .WIDTH      (WIDTH),
      .LSB_FIRST  (LSB_FIRST),
      .IDLE_LEVEL (IDLE_LEVEL),
      .CW         (CW)
   ) u_shifter (
      .clk_sys    (C),
      .rst_b      (RN),
      .cmd        (sh_cmd),
      .load_data  (sh_data),
      .load_last  (sh_last),
      .d1         (D1),
      .d2         (D2),
      .last_beat  (last_beat),
      .frame_last (frame_last)
   );

   assign IN_READY = ready_q;
   assign OCE      = oce_q;
   assign UNDERRUN = underrun_q;
   assign BUSY     = (state_q != ST_IDLE) || hold_valid_q;

endmodule

// File: tb/tb_oddr_tx_sequencer.sv
// Bench for oddr_tx_sequencer: directed frames plus random traffic against a beat-token queue model.
module tb_oddr_tx_sequencer;

   logic       C = 1'b0;
   always #5 C = ~C;

   logic       rn_drv = 1'b0;
   logic       en = 1'b1;
   logic       valid = 1'b0;
   logic       last = 1'b0;
   logic [7:0] data = 8'h00;
   int         sel = 0;

   logic rn0, rn1;
   assign rn0 = (sel == 0) ? rn_drv : 1'b0;
   assign rn1 = (sel == 1) ? rn_drv : 1'b0;

   logic rdy0, d10, d20, oce0, busy0, und0;
   logic rdy1, d11, d21, oce1, busy1, und1;

   oddr_tx_sequencer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .GAP_BEATS(2)) dut0 (
      .C(C), .RN(rn0), .EN(en), .IN_DATA(data), .IN_VALID(valid), .IN_LAST(last),
      .IN_READY(rdy0), .D1(d10), .D2(d20), .OCE(oce0), .BUSY(busy0), .UNDERRUN(und0));

   oddr_tx_sequencer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP_BEATS(0)) dut1 (
      .C(C), .RN(rn1), .EN(en), .IN_DATA(data[3:0]), .IN_VALID(valid), .IN_LAST(last),
      .IN_READY(rdy1), .D1(d11), .D2(d21), .OCE(oce1), .BUSY(busy1), .UNDERRUN(und1));

   // Reference model: the line is a queue of pending beat tokens {mid_end, d1, d2};
   // a word expands into its beats (plus idle tokens for the frame gap) when the queue runs dry.
   int   m_w = 8, m_gap = 2;
   bit   m_lsb = 1'b1;
   int   pq[$];
   int   hq[$];
   bit   m_ready = 0, m_oce = 0, m_und = 0, m_d1 = 1, m_d2 = 1, m_active = 0, m_mid = 0;
   int   checks = 0, errors = 0;

   logic [1:0] b4_pairs [7] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
   bit         b4_busy  [7] = '{1, 1, 1, 1, 1, 1, 0};
   logic [1:0] bb_pairs [8] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11};

   task automatic expand(input int wl);
      int  b1, b2, tok;
      bit  lst;
      lst = wl[8];
      for (int i = 0; i < m_w / 2; i++) begin
         if (m_lsb) begin b1 = 2 * i;         b2 = 2 * i + 1;       end
         else       begin b1 = m_w - 1 - 2*i; b2 = m_w - 2 - 2 * i; end
         tok = int'({wl[b1], wl[b2]});
         if (i == m_w / 2 - 1 && !lst) tok = tok | 4;
         pq.push_back(tok);
      end
      if (lst) for (int g = 0; g < m_gap; g++) pq.push_back(3);
   endtask

   task automatic model_edge();
      bit acc, direct;
      int tok;
      acc = valid && m_ready;
      if (!rn_drv) begin
         pq.delete(); hq.delete();
         m_ready = 0; m_oce = 0; m_und = 0; m_d1 = 1; m_d2 = 1; m_active = 0; m_mid = 0;
         return;
      end
      direct = 0;
      m_oce  = en;
      m_und  = 0;
      if (en) begin
         if (pq.size() == 0) begin
            if (hq.size() != 0) expand(hq.pop_front());
            else if (acc) begin expand(int'({last, data})); direct = 1; end
         end
         if (pq.size() == 0) begin
            m_und = m_mid; m_d1 = 1; m_d2 = 1; m_active = 0; m_mid = 0;
         end else begin
            tok = pq.pop_front();
            m_d1 = tok[1]; m_d2 = tok[0]; m_mid = tok[2]; m_active = 1;
         end
      end
      if (acc && !direct) hq.push_back(int'({last, data}));
      m_ready = (hq.size() == 0);
   endtask

   function automatic logic [5:0] dut_obs();
      if (sel == 1) return {rdy1, busy1, oce1, und1, d11, d21};
      return {rdy0, busy0, oce0, und0, d10, d20};
   endfunction

   task automatic check_cycle(string tag);
      logic [5:0] obs, exp;
      obs = dut_obs();
      exp = {m_ready, m_active || (hq.size() != 0), m_oce, m_und, m_d1, m_d2};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed {rdy,busy,oce,und,d1,d2}=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic expect_obs(string tag, logic [5:0] mask, logic [5:0] exp);
      logic [5:0] obs;
      obs = dut_obs();
      checks++;
      assert ((obs & mask) === (exp & mask)) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b mask=%b", tag, obs, exp, mask);
      end
   endtask

   task automatic step(string tag);
      @(posedge C);
      model_edge();
      @(negedge C);
      check_cycle(tag);
   endtask

   task automatic random_phase(string tag, int n);
      for (int i = 0; i < n; i++) begin
         rn_drv = ($urandom_range(99) != 0);
         en     = ($urandom_range(99) < 85);
         valid  = ($urandom_range(1) == 1);
         last   = ($urandom_range(9) < 3);
         data   = 8'($urandom);
         step(tag);
      end
   endtask

   localparam logic [5:0] M_ALL  = 6'b111111;
   localparam logic [5:0] M_PAIR = 6'b000011;

   initial begin
      // Reset with valid asserted: nothing may be accepted.
      rn_drv = 0; valid = 1; data = 8'h5A; last = 0; en = 1;
      repeat (3) step("reset");
      expect_obs("reset_state", M_ALL, 6'b000011);
      rn_drv = 1; valid = 0;
      step("release");
      expect_obs("release_state", M_ALL, 6'b101011);

      // Single word with LAST from IDLE, then the frame gap.
      valid = 1; data = 8'hB4; last = 1;
      for (int i = 0; i < 7; i++) begin
         step("b4");
         valid = 0;
         expect_obs("b4_pair", M_PAIR, {4'b0, b4_pairs[i]});
         expect_obs("b4_busy", 6'b010000, {1'b0, b4_busy[i], 4'b0});
      end

      // Back-to-back words, no bubble, no underrun.
      valid = 1; data = 8'h0F; last = 0;
      for (int i = 0; i < 8; i++) begin
         step("b2b");
         if (i == 0) begin data = 8'hF0; last = 1; end
         else valid = 0;
         expect_obs("b2b_pair", 6'b000111, {4'b0, bb_pairs[i]});
      end
      repeat (3) step("b2b_tail");

      // Underrun after a non-last word.
      valid = 1; data = 8'hAA; last = 0;
      step("und_b0");
      valid = 0;
      repeat (3) step("und_beats");
      expect_obs("und_last_beat", 6'b000111, 6'b000001);
      step("und_pulse");
      expect_obs("und_pulse", 6'b000111, 6'b000111);
      step("und_clear");
      expect_obs("und_clear", 6'b000100, 6'b000000);

      // Pause at beat1.
      valid = 1; data = 8'hB4; last = 1;
      step("pause_b0");
      valid = 0;
      step("pause_b1");
      en = 0;
      repeat (3) begin
         step("pause_hold");
         expect_obs("pause_hold", 6'b001111, 6'b000010);
      end
      en = 1;
      step("pause_b2");
      expect_obs("pause_b2", 6'b001111, 6'b001011);
      step("pause_b3");
      expect_obs("pause_b3", M_PAIR, 6'b000001);
      repeat (3) step("pause_tail");

      // Reset mid-word, then a clean word.
      valid = 1; data = 8'hB4; last = 1;
      step("mid_b0");
      valid = 0;
      repeat (2) step("mid_beats");
      rn_drv = 0;
      step("mid_reset");
      expect_obs("mid_reset", M_ALL, 6'b000011);
      rn_drv = 1;
      step("mid_release");
      valid = 1; data = 8'h33; last = 1;
      step("w33_b0");
      expect_obs("w33_b0", M_PAIR, 6'b000011);
      valid = 0;
      step("w33_b1");
      expect_obs("w33_b1", M_PAIR, 6'b000000);
      repeat (5) step("w33_tail");

      random_phase("rand_cfg0", 800);

      // Second configuration: WIDTH=4, MSB first, no gap.
      rn_drv = 0; valid = 0; en = 1;
      repeat (2) step("cfg1_reset");
      sel = 1; m_w = 4; m_lsb = 0; m_gap = 0;
      step("cfg1_reset");
      expect_obs("cfg1_reset", M_ALL, 6'b000011);
      rn_drv = 1;
      step("cfg1_release");
      valid = 1; data = 8'h05; last = 1;
      step("cfg1_w5_b0");
      expect_obs("cfg1_w5_b0", M_PAIR, 6'b000001);
      valid = 0; rn_drv = 0;
      step("cfg1_mid_reset");
      expect_obs("cfg1_mid_reset", M_ALL, 6'b000011);
      rn_drv = 1;
      step("cfg1_release2");
      valid = 1; data = 8'h33; last = 1;
      step("cfg1_w3_b0");
      expect_obs("cfg1_w3_b0", M_PAIR, 6'b000000);
      valid = 0;
      step("cfg1_w3_b1");
      expect_obs("cfg1_w3_b1", M_PAIR, 6'b000011);
      step("cfg1_idle");
      expect_obs("cfg1_idle", M_ALL, 6'b101011);

      random_phase("rand_cfg1", 800);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
